// File: rtl/rect_plotter.sv
// Rectangle fill engine: one latched draw command becomes a raster-ordered
// stream of registered pixel writes, clipped against the visible screen.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SIZE_W   = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [SIZE_W-1:0]   w_in,
  input  logic [SIZE_W-1:0]   h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int XY_W  = (X_W > Y_W) ? X_W : Y_W;
  localparam int SUM_W = ((XY_W > SIZE_W + 1) ? XY_W : SIZE_W + 1) + 1;
  localparam logic [SIZE_W:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t state, state_nxt;

  logic [SIZE_W:0]   w_q, h_q, dx, dy;
  logic [X_W-1:0]    ox;
  logic [Y_W-1:0]    oy;
  logic [COLOUR_W-1:0] colour_q;
  logic [SUM_W-1:0]  px, py;
  logic              row_end, last_px, zero_size;
  logic              load, drawing, draw_q;

  assign px        = SUM_W'(ox) + SUM_W'(dx);
  assign py        = SUM_W'(oy) + SUM_W'(dy);
  assign row_end   = (dx == w_q - ONE);
  assign last_px   = row_end && (dy == h_q - ONE);
  assign zero_size = !mode && ((w_in == '0) || (h_in == '0));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_size ? FIN : DRAW;
      DRAW:    if (last_px) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy extends one cycle past DRAW so it covers the registered last pixel
  always_comb begin
    load    = (state == IDLE) && start;
    drawing = (state == DRAW);
    busy    = drawing || draw_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      w_q        <= '0;
      h_q        <= '0;
      ox         <= '0;
      oy         <= '0;
      colour_q   <= '0;
      dx         <= '0;
      dy         <= '0;
      draw_q     <= 1'b0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      draw_q   <= drawing;
      done     <= (state == FIN);
      vga_plot <= drawing && (px < SUM_W'(SCREEN_W)) && (py < SUM_W'(SCREEN_H));
      if (load) begin
        colour_q <= colour_in;
        dx       <= '0;
        dy       <= '0;
        if (mode) begin
          ox  <= '0;
          oy  <= '0;
          w_q <= (SIZE_W+1)'(SCREEN_W);
          h_q <= (SIZE_W+1)'(SCREEN_H);
        end else begin
          ox  <= x_in;
          oy  <= y_in;
          w_q <= {1'b0, w_in};
          h_q <= {1'b0, h_in};
        end
      end else if (drawing) begin
        vga_x      <= px[X_W-1:0];
        vga_y      <= py[Y_W-1:0];
        vga_colour <= colour_q;
        if (row_end) begin
          dx <= '0;
          dy <= dy + ONE;
        end else begin
          dx <= dx + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed and randomized checks of rect_plotter against a pixel-list model
// built from the rectangle/clip rules.
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [7:0] w_in;
  logic [7:0] h_in;
  logic [2:0] colour_in;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_vec = 0;
  int n_err = 0;

  rect_plotter dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    x_in      = 8'($urandom);
    y_in      = 7'($urandom);
    w_in      = 8'($urandom);
    h_in      = 8'($urandom);
    colour_in = 3'($urandom);
    mode      = 1'($urandom);
  endtask

  // Called at a negedge; drives start in the current cycle and returns at the
  // negedge of the cycle following done.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int c, input int m);
    int ox, oy, ew, eh, area, exp_done, n_exp, cyc, done_cyc, n_plot;
    int q[$];
    ox = m ? 0 : x;
    oy = m ? 0 : y;
    ew = m ? 160 : w;
    eh = m ? 120 : h;
    for (int r = 0; r < eh; r++)
      for (int k = 0; k < ew; k++)
        if (ox + k < 160 && oy + r < 120)
          q.push_back(((ox + k) << 10) | ((oy + r) << 3) | c);
    n_exp    = q.size();
    area     = ew * eh;
    exp_done = (area == 0) ? 2 : area + 2;

    x_in = 8'(x); y_in = 7'(y); w_in = 8'(w); h_in = 8'(h);
    colour_in = 3'(c); mode = 1'(m); start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    scramble();
    cyc = 1; done_cyc = -1; n_plot = 0;
    while (done_cyc < 0 && cyc < exp_done + 20) begin
      if (vga_plot) begin
        n_plot++;
        chk("busy_during_plot", 32'(busy), 32'd1);
        if (q.size() > 0)
          chk("pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'(q.pop_front()));
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      // stray starts while busy and while finishing must be ignored
      start = (cyc == exp_done - 1) || (cyc == 3 && area >= 5);
      if (start) scramble();
      @(negedge CLOCK_50);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("plot_count", 32'(n_plot), 32'(n_exp));
    chk("done_one_shot", 32'(done), 32'd0);
    chk("no_plot_after", 32'(vga_plot), 32'd0);
  endtask

  initial begin
    int bad_plot, bad_done;
    reset = 1'b1;
    start = 1'b0;
    scramble();
    mode = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("reset_outputs", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("idle_busy", 32'(busy), 32'd0);

    // reset in the fifth DRAW cycle of a 4x4 command
    x_in = 8'd30; y_in = 7'd30; w_in = 8'd4; h_in = 8'd4;
    colour_in = 3'd5; mode = 1'b0; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    chk("plot_before_reset", 32'(vga_plot), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_midrun", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    bad_plot = 0; bad_done = 0;
    repeat (30) begin
      @(negedge CLOCK_50);
      if (vga_plot) bad_plot++;
      if (done) bad_done++;
    end
    chk("plot_after_reset", 32'(bad_plot), 32'd0);
    chk("done_after_reset", 32'(bad_done), 32'd0);

    run_cmd(10, 20, 3, 2, 3'b100, 0);
    run_cmd(158, 119, 4, 2, 3'b011, 0);
    run_cmd(40, 40, 0, 5, 3'b010, 0);
    run_cmd(40, 40, 5, 0, 3'b010, 0);
    run_cmd(0, 0, 0, 0, 3'b000, 1);
    run_cmd(5, 5, 1, 1, 3'b111, 0);
    run_cmd(250, 127, 8, 3, 3'b001, 0);
    run_cmd(0, 0, 255, 1, 3'b110, 0);
    for (int i = 0; i < 25; i++)
      run_cmd($urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 20), $urandom_range(0, 12),
              $urandom_range(0, 7), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
